seg_p2s64: RTL
==============

# seg_p2s64

Parallel-to-serial stage that sits directly downstream of the 64-bit 2:1 display-data multiplexer (MUX2T1_64). It captures the selected 64-bit word on a start request and shifts it MSB-first into the board's external seven-segment shift-register chain. It generates the serial clock, serial data and a latch/enable pulse, and reports ready/done to the display controller that drives the mux select.

## Interface
Parameters:
- DATA_W, 64, word width; must match the mux output width.
- CLK_DIV, 2, system-clock cycles per serial-clock half-period; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- data  in  DATA_W  parallel word from MUX2T1_64 output o; sampled only on an accepted start.
- start  in  1  capture-and-send request; level sampled each clk.
- ready  out  1  high in IDLE; start is accepted only when ready=1.
- done  out  1  one-cycle pulse when a full word has been shifted and latched.
- sclk  out  1  serial clock to the shift-register chain; idles low.
- sout  out  1  serial data; changes only while sclk=0.
- pen  out  1  latch/output-enable pulse to the chain after the last bit.

## Operation
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - ready=1, sclk=0, pen=0.
  - start=1 captures data into a DATA_W shift register, clears the bit counter and the divider, and moves to SHIFT.
- SHIFT, per bit:
  - sout = shreg[DATA_W-1].
  - First CLK_DIV cycles: sclk=0. Next CLK_DIV cycles: sclk=1.
  - On the falling transition (end of the high half): shreg shifts left by 1, zero-fill, and the bit counter increments.
  - After bit DATA_W-1 completes, the FSM moves to LATCH with sclk=0.
- LATCH:
  - pen=1 for CLK_DIV cycles; sout holds 0.
  - Then the FSM moves to IDLE and done pulses for exactly one cycle, the first IDLE cycle.
- start while ready=0 is ignored, not queued. data changes during a transfer have no effect.
- start high in the done cycle is accepted; this gives back-to-back words with no gap cycle.
- Bit counter: $clog2(DATA_W)+1 bits. Divider: 8 bits. Neither may wrap during a legal transfer.

## Timing
- Reset values: ready=0 while rst_n=0, ready=1 on the first cycle after release; done=0, sclk=0, sout=0, pen=0; FSM=IDLE; shreg=0.
- Accepted start at edge k: SHIFT begins cycle k+1 with sout=data[DATA_W-1].
- Bit i (0-based) is driven on sout from cycle k+1+2·i·CLK_DIV. sclk rises CLK_DIV cycles later.
- pen is high for cycles k+1+2·DATA_W·CLK_DIV through k+(2·DATA_W+1)·CLK_DIV.
- done pulses at cycle k+1+(2·DATA_W+1)·CLK_DIV.
- Busy duration is (2·DATA_W+1)·CLK_DIV cycles; 258 for the defaults.
- All outputs are registered, with no combinational path from start or data to any output.
- rst_n low mid-transfer aborts immediately (async): outputs go to reset values and no done pulse is issued for the aborted word.

## Structure
- Shared package seg_p2s_pkg holds:
  - the state enum {IDLE, SHIFT, LATCH};
  - the DATA_W default constant;
  - the width function for the bit counter.
- One sub-module, seg_clk_en: parameterised CLK_DIV counter producing a one-cycle half-period tick, with clear input and async active-low reset. The FSM toggles sclk on that tick.
- Everything else lives in seg_p2s64.

## Test plan
- Reset then idle: hold rst_n=0 for 5 cycles, release, no start → ready=1; sclk, sout, pen, done remain 0 for 300 cycles.
- Single word, defaults: data=64'h8000_0000_0000_0001, start pulse → sout=1 for bit 0, 0 for bits 1..62, 1 for bit 63; exactly 64 sclk rising edges; pen high 2 cycles; done at start+259.
- Pattern integrity: data=64'hA5A5_5A5A_0F0F_F0F0 → a bench-side shift register clocked on sclk rising holds exactly that value when pen rises.
- Busy rejection and back-to-back: start held high throughout with data changed mid-transfer → first word shifted unchanged; second word captured in the done cycle; the gap between the last pen and the next sclk rise is CLK_DIV+1 cycles.
- Reset mid-transfer: rst_n low after bit 20 → same cycle sclk=0, sout=0, pen=0, no done. After release, a new start sends a fresh full 64 bits.
- CLK_DIV=1 build: data=64'h1 → busy 129 cycles; sclk period 2 cycles; sout=1 only on bit 63.

Source files
------------

// File: rtl/seg_p2s_pkg.sv
// Shared types and constants for the seven-segment parallel-to-serial stage.
package seg_p2s_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  localparam int DATA_W_DEF = 64;

  // One extra bit so the counter can hold DATA_W itself without wrapping.
  function automatic int bitcnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seg_clk_en.sv
// Half-period tick generator: pulses tick for one cycle every CLK_DIV enabled cycles.
// clr restarts the count; counting only advances while en is high.
module seg_clk_en #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [7:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == 8'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_p2s64.sv
// Captures a DATA_W word on start and shifts it MSB-first to the segment chain,
// then pulses pen for CLK_DIV cycles and done for one cycle; start is ignored while busy.
module seg_p2s64
  import seg_p2s_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  output logic              ready,
  output logic              done,
  output logic              sclk,
  output logic              sout,
  output logic              pen
);

  localparam int CW = bitcnt_w(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              sout_q, sout_d;
  logic              pen_q, pen_d;

  logic tick;
  logic accept;

  // ready is only ever set in IDLE, so it doubles as the idle qualifier.
  assign accept = ready_q && start;

  seg_clk_en #(.CLK_DIV(CLK_DIV)) u_clk_en (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q != IDLE),
    .clr   (accept),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    sout_d  = sout_q;
    pen_d   = pen_q;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          state_d = SHIFT;
          shreg_d = data;
          bcnt_d  = '0;
          sout_d  = data[DATA_W-1];
          ready_d = 1'b0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: the chain has clocked the bit in, present the next one.
            sclk_d  = 1'b0;
            shreg_d = shreg_q << 1;
            bcnt_d  = bcnt_q + CW'(1);
            if (bcnt_q == CW'(DATA_W - 1)) begin
              state_d = LATCH;
              pen_d   = 1'b1;
              sout_d  = 1'b0;
            end else begin
              sout_d = shreg_q[DATA_W-2];
            end
          end
        end
      end
      LATCH: begin
        if (tick) begin
          state_d = IDLE;
          pen_d   = 1'b0;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sout_q  <= 1'b0;
      pen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sout_q  <= sout_d;
      pen_q   <= pen_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign sclk  = sclk_q;
  assign sout  = sout_q;
  assign pen   = pen_q;

endmodule
